// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the multicycle RV64 control path:
//               opcode constants, FSM state encoding, instruction classes,
//               ULA operation codes, Mux2 write-back encodings and the
//               opcode/funct decoder used by the control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes, IR[6:0]
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 values accepted for R-type
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    // ULA operation codes
    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;

    // Mux2 (write-back source) encodings
    localparam logic [1:0] WB_MEM    = 2'b00;
    localparam logic [1:0] WB_ALU    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_PCIMM  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R       = 3'd0,
        CL_ADDI    = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_JAL     = 3'd5,
        CL_AUIPC   = 3'd6,
        CL_ILLEGAL = 3'd7
    } instr_class_t;

    // Classify the instruction held in IR. Anything not explicitly
    // supported (jalr, R-type with other funct7, branch funct3 010/011,
    // unknown opcodes) maps to CL_ILLEGAL.
    function automatic instr_class_t decode_class(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        instr_class_t cls;
        cls = CL_ILLEGAL;
        case (opcode)
            OP_R:      cls = ((funct7 == F7_ADD) || (funct7 == F7_SUB)) ? CL_R : CL_ILLEGAL;
            OP_ADDI:   cls = CL_ADDI;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = ((funct3 == 3'b010) || (funct3 == 3'b011)) ? CL_ILLEGAL : CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_AUIPC:  cls = CL_AUIPC;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_control
// Description : Combinational ULA operation select from instruction class
//               and funct fields.
//   i_cls      in  instruction class
//   i_funct3   in  IR[14:12] (reserved for future ULA operations)
//   i_funct7   in  IR[31:25]
//   o_alu_ctrl out ULA 'sinal' code
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control
    import riscv_pkg::*;
(
    input  instr_class_t i_cls,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    output logic [3:0]   o_alu_ctrl
);

    // funct3 selects nothing yet; every branch compares by subtraction.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^i_funct3;

    always_comb begin
        o_alu_ctrl = ALU_NOP;
        case (i_cls)
            CL_R:       o_alu_ctrl = (i_funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            CL_BRANCH:  o_alu_ctrl = ALU_SUB;
            CL_ADDI,
            CL_LOAD,
            CL_STORE,
            CL_AUIPC,
            CL_JAL:     o_alu_ctrl = ALU_ADD;
            default:    o_alu_ctrl = ALU_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle
// Description : Multicycle control FSM for the RV64 datapath. Drives write
//               enables, mux selects and the ULA code per state, counts
//               retired instructions and traps unsupported opcodes.
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   run      in   start request, sampled only in IDLE
//   opcode   in   IR[6:0]
//   funct3   in   IR[14:12]
//   funct7   in   IR[31:25]
//   flag     in   ULA branch-taken flag
//   pc_we, ir_we, rf_we, mem_we  out  write enables
//   alu_ctrl out  ULA operation code
//   sel_b, sel_wb, pc_src, sel_a out mux selects (Mux1, Mux2, Mux3, Mux4)
//   illegal  out  sticky unsupported-opcode trap
//   busy     out  high outside IDLE and TRAP
//   retired  out  retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             flag,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             mem_we,
    output logic [3:0]       alu_ctrl,
    output logic             sel_b,
    output logic [1:0]       sel_wb,
    output logic             pc_src,
    output logic             sel_a,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    state_t       r_state;
    state_t       w_next;
    instr_class_t w_cls;
    logic [3:0]   w_alu_ctrl;
    logic         w_sel_a;
    logic         w_sel_b;
    logic [1:0]   w_sel_wb;
    logic         w_retire;
    logic [CNT_W-1:0] r_retired;

    // IR is stable from DECODE until the next FETCH, so the class can be
    // re-derived combinationally every cycle rather than latched.
    assign w_cls = decode_class(opcode, funct3, funct7);

    alu_control u_alu_control (
        .i_cls      (w_cls),
        .i_funct3   (funct3),
        .i_funct7   (funct7),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // Per-class datapath selects, applied from EXEC through WB.
    // sel_a=0 routes PC into the ULA (auipc, jal target); sel_b=1 picks rs2.
    always_comb begin
        w_sel_a  = 1'b1;
        w_sel_b  = 1'b0;
        w_sel_wb = WB_MEM;
        case (w_cls)
            CL_R:      begin w_sel_b = 1'b1; w_sel_wb = WB_ALU; end
            CL_ADDI:   w_sel_wb = WB_ALU;
            CL_BRANCH: w_sel_b  = 1'b1;
            CL_AUIPC:  begin w_sel_a = 1'b0; w_sel_wb = WB_ALU; end
            CL_JAL:    begin w_sel_a = 1'b0; w_sel_wb = WB_PC4; end
            default:   ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An instruction retires when its final state hands control back to FETCH.
    assign w_retire = ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB))
                      && (w_next == ST_FETCH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

    // Outputs are Moore per (state, class); reset forces r_state to IDLE
    // asynchronously, so every enable drops in the same cycle as reset.
    always_comb begin
        w_next   = r_state;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        mem_we   = 1'b0;
        alu_ctrl = ALU_NOP;
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        sel_wb   = WB_MEM;
        pc_src   = 1'b0;
        illegal  = 1'b0;
        busy     = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) begin
                    w_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_we  = 1'b1;
                w_next = ST_DECODE;
            end

            ST_DECODE: begin
                w_next = (w_cls == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                alu_ctrl = w_alu_ctrl;
                sel_a    = w_sel_a;
                sel_b    = w_sel_b;
                sel_wb   = w_sel_wb;
                case (w_cls)
                    CL_LOAD,
                    CL_STORE:  w_next = ST_MEM;
                    CL_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_src = flag;
                        w_next = ST_FETCH;
                    end
                    CL_ILLEGAL: w_next = ST_TRAP;
                    default:    w_next = ST_WB;
                endcase
            end

            ST_MEM: begin
                alu_ctrl = w_alu_ctrl;
                sel_a    = w_sel_a;
                sel_b    = w_sel_b;
                sel_wb   = w_sel_wb;
                if (w_cls == CL_STORE) begin
                    mem_we = 1'b1;
                    pc_we  = 1'b1;
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_WB: begin
                alu_ctrl = w_alu_ctrl;
                sel_a    = w_sel_a;
                sel_b    = w_sel_b;
                sel_wb   = w_sel_wb;
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                pc_src   = (w_cls == CL_JAL);
                w_next   = ST_FETCH;
            end

            ST_TRAP: begin
                illegal = 1'b1;
                busy    = 1'b0;
            end

            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle
// Description : Self-checking bench for unidade_controle: a per-cycle vector
//               table for an instruction stream, then directed sequences for
//               traps, asynchronous reset mid-writeback and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        flag;

    logic        pc_we, ir_we, rf_we, mem_we, sel_b, pc_src, sel_a, illegal, busy;
    logic [3:0]  alu_ctrl;
    logic [1:0]  sel_wb;
    logic [15:0] retired;

    logic        pc_we2, ir_we2, rf_we2, mem_we2, sel_b2, pc_src2, sel_a2, illegal2, busy2;
    logic [3:0]  alu_ctrl2;
    logic [1:0]  sel_wb2;
    logic [1:0]  retired2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    unidade_controle #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .flag(flag), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .mem_we(mem_we), .alu_ctrl(alu_ctrl), .sel_b(sel_b), .sel_wb(sel_wb),
        .pc_src(pc_src), .sel_a(sel_a), .illegal(illegal), .busy(busy), .retired(retired)
    );

    unidade_controle #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .flag(flag), .pc_we(pc_we2), .ir_we(ir_we2), .rf_we(rf_we2),
        .mem_we(mem_we2), .alu_ctrl(alu_ctrl2), .sel_b(sel_b2), .sel_wb(sel_wb2),
        .pc_src(pc_src2), .sel_a(sel_a2), .illegal(illegal2), .busy(busy2), .retired(retired2)
    );

    // Packed view: {pc_we, ir_we, rf_we, mem_we, alu_ctrl, sel_b, sel_wb, pc_src, sel_a, illegal, busy}
    logic [15:0] ovec;
    assign ovec = {pc_we, ir_we, rf_we, mem_we, alu_ctrl, sel_b, sel_wb, pc_src, sel_a, illegal, busy};

    function automatic logic [15:0] ov(input logic pc, input logic ir, input logic rf,
                                       input logic mem, input logic [3:0] alu, input logic sb,
                                       input logic [1:0] wb, input logic ps, input logic sa,
                                       input logic ill, input logic bs);
        return {pc, ir, rf, mem, alu, sb, wb, ps, sa, ill, bs};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        run;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        flag;
        logic [15:0] eo;
        logic [15:0] er;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic fl, input logic [15:0] eo,
                        input logic [15:0] er);
        vec_t v;
        v.run = r; v.op = op; v.f3 = f3; v.f7 = f7; v.flag = fl; v.eo = eo; v.er = er;
        tbl.push_back(v);
    endtask

    localparam logic [6:0] R = 7'b0110011, ADDI = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                           AUIPC = 7'b0010111, JALR = 7'b1100111;
    localparam logic [6:0] F7A = 7'b0000000, F7S = 7'b0100000;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] o_idle, o_fetch, o_dec, o_trap;
        logic [1:0]  wexp [5];

        o_idle  = 16'h0000;
        o_fetch = ov(0,1,0,0,4'b0,0,2'b00,0,0,0,1);
        o_dec   = ov(0,0,0,0,4'b0,0,2'b00,0,0,0,1);
        o_trap  = ov(0,0,0,0,4'b0,0,2'b00,0,0,1,0);

        // add, sub, load, store, beq(taken), bne(not taken), addi, auipc, jal, jalr(trap)
        push(0, R, 3'b000, F7A, 0, o_idle, 0);
        push(1, R, 3'b000, F7A, 0, o_idle, 0);
        push(1, R, 3'b000, F7A, 0, o_fetch, 0);
        push(1, R, 3'b000, F7A, 0, o_dec, 0);
        push(1, R, 3'b000, F7A, 0, ov(0,0,0,0,A_ADD,1,2'b01,0,1,0,1), 0);
        push(1, R, 3'b000, F7A, 0, ov(1,0,1,0,A_ADD,1,2'b01,0,1,0,1), 0);
        push(0, R, 3'b000, F7S, 0, o_fetch, 1);
        push(0, R, 3'b000, F7S, 0, o_dec, 1);
        push(0, R, 3'b000, F7S, 0, ov(0,0,0,0,A_SUB,1,2'b01,0,1,0,1), 1);
        push(0, R, 3'b000, F7S, 0, ov(1,0,1,0,A_SUB,1,2'b01,0,1,0,1), 1);
        push(0, LD, 3'b011, F7A, 0, o_fetch, 2);
        push(0, LD, 3'b011, F7A, 0, o_dec, 2);
        push(0, LD, 3'b011, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b00,0,1,0,1), 2);
        push(0, LD, 3'b011, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b00,0,1,0,1), 2);
        push(0, LD, 3'b011, F7A, 0, ov(1,0,1,0,A_ADD,0,2'b00,0,1,0,1), 2);
        push(0, ST, 3'b011, F7A, 0, o_fetch, 3);
        push(0, ST, 3'b011, F7A, 0, o_dec, 3);
        push(0, ST, 3'b011, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b00,0,1,0,1), 3);
        push(0, ST, 3'b011, F7A, 0, ov(1,0,0,1,A_ADD,0,2'b00,0,1,0,1), 3);
        push(0, BR, 3'b000, F7A, 1, o_fetch, 4);
        push(0, BR, 3'b000, F7A, 1, o_dec, 4);
        push(0, BR, 3'b000, F7A, 1, ov(1,0,0,0,A_SUB,1,2'b00,1,1,0,1), 4);
        push(0, BR, 3'b001, F7A, 0, o_fetch, 5);
        push(0, BR, 3'b001, F7A, 0, o_dec, 5);
        push(0, BR, 3'b001, F7A, 0, ov(1,0,0,0,A_SUB,1,2'b00,0,1,0,1), 5);
        push(0, ADDI, 3'b000, F7A, 0, o_fetch, 6);
        push(0, ADDI, 3'b000, F7A, 0, o_dec, 6);
        push(0, ADDI, 3'b000, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b01,0,1,0,1), 6);
        push(0, ADDI, 3'b000, F7A, 0, ov(1,0,1,0,A_ADD,0,2'b01,0,1,0,1), 6);
        push(0, AUIPC, 3'b000, F7A, 0, o_fetch, 7);
        push(0, AUIPC, 3'b000, F7A, 0, o_dec, 7);
        push(0, AUIPC, 3'b000, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b01,0,0,0,1), 7);
        push(0, AUIPC, 3'b000, F7A, 0, ov(1,0,1,0,A_ADD,0,2'b01,0,0,0,1), 7);
        push(0, JAL, 3'b000, F7A, 0, o_fetch, 8);
        push(0, JAL, 3'b000, F7A, 0, o_dec, 8);
        push(0, JAL, 3'b000, F7A, 0, ov(0,0,0,0,A_ADD,0,2'b10,0,0,0,1), 8);
        push(0, JAL, 3'b000, F7A, 0, ov(1,0,1,0,A_ADD,0,2'b10,1,0,0,1), 8);
        push(1, JALR, 3'b000, F7A, 0, o_fetch, 9);
        push(1, JALR, 3'b000, F7A, 0, o_dec, 9);
        push(1, JALR, 3'b000, F7A, 0, o_trap, 9);
        push(1, JALR, 3'b000, F7A, 0, o_trap, 9);

        reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; flag = 1'b0;
        #3;
        check("reset_outputs", {16'h0, ovec}, {16'h0, o_idle});
        check("reset_retired", {16'h0, retired}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clock);
            run = tbl[i].run; opcode = tbl[i].op; funct3 = tbl[i].f3;
            funct7 = tbl[i].f7; flag = tbl[i].flag;
            #1;
            check($sformatf("vec%0d_ctrl", i), {16'h0, ovec}, {16'h0, tbl[i].eo});
            check($sformatf("vec%0d_retired", i), {16'h0, retired}, {16'h0, tbl[i].er});
        end

        // R-type with unsupported funct7 traps; reset clears the trap.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("trap_cleared_by_reset", {31'h0, illegal}, 32'd0);
        check("retired_cleared", {16'h0, retired}, 32'd0);
        @(negedge clock);
        reset = 1'b0; run = 1'b1; opcode = R; funct7 = 7'b0000001; funct3 = 3'b000;
        repeat (3) @(negedge clock);
        #1;
        check("bad_funct7_trap", {16'h0, ovec}, {16'h0, o_trap});

        // Branch with funct3=010 traps.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; opcode = BR; funct3 = 3'b010; funct7 = F7A;
        repeat (3) @(negedge clock);
        #1;
        check("branch_f3_010_trap", {31'h0, illegal}, 32'd1);

        // Asynchronous reset in the middle of addi writeback.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; run = 1'b1; opcode = ADDI; funct3 = 3'b000;
        repeat (8) @(negedge clock);
        #1;
        check("addi_wb_rf_we", {31'h0, rf_we}, 32'd1);
        check("addi_wb_retired", {16'h0, retired}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_rf_we", {31'h0, rf_we}, 32'd0);
        check("async_reset_pc_we", {31'h0, pc_we}, 32'd0);
        check("async_reset_outputs", {16'h0, ovec}, {16'h0, o_idle});
        check("async_reset_retired", {16'h0, retired}, 32'd0);
        @(negedge clock);
        reset = 1'b0; run = 1'b1;
        @(posedge clock);
        #1;
        check("restart_fetch", {16'h0, ovec}, {16'h0, o_fetch});

        // 2-bit counter wraps over five 4-cycle instructions.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("wrap_reset", {30'h0, retired2}, 32'd0);
        @(negedge clock);
        reset = 1'b0; run = 1'b1; opcode = ADDI;
        wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge clock);
            #1;
            check($sformatf("wrap_retired_%0d", k), {30'h0, retired2}, {30'h0, wexp[k]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
